adder_256bit: RTL and testbench
===============================

// Module: adder_256bit
// PURPOSE
//   Multi-cycle 256-bit adder with carry-in.
//   - Computes sum/cout = din_one + din_two + cin in fixed-width slices, one slice per clock.
//   - Presents the registered result with a one-cycle done pulse.
//   - Free-running: after each result it recaptures operands and starts again.
//   - Used where a full 256-bit single-cycle carry chain would limit clock frequency.
// PARAMETERS
//   DATA_W   256  operand/sum width
//   CHUNK_W  32   bits added per cycle; DATA_W must be an integer multiple of CHUNK_W
//   (NCHUNK = DATA_W/CHUNK_W, default 8)
// PORTS
//   clk      in   1       single clock, all state on rising edge
//   rst      in   1       synchronous reset, active-high
//   din_one  in   DATA_W  operand A
//   din_two  in   DATA_W  operand B
//   cin      in   1       carry-in added at bit 0
//   sum      out  DATA_W  registered result, low DATA_W bits of A+B+cin
//   cout     out  1       registered carry-out of bit DATA_W-1
//   done     out  1       one-cycle pulse: sum/cout just updated with a new result
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge):
//     - state=LOAD, sum=0, cout=0, done=0.
//     - Internal operand, carry and partial-sum registers are cleared.
//     - Reset mid-operation abandons the computation; no done pulse.
//   - FSM states LOAD -> ADD -> DONE -> LOAD, running continuously while rst=0.
//   - LOAD (1 cycle):
//     - Capture din_one, din_two and cin into internal registers.
//     - Clear the chunk index and the partial sum; set the running carry to the captured cin.
//   - ADD (NCHUNK cycles, index k = 0..NCHUNK-1):
//     - {c, p[k]} = a[k] + b[k] + carry, where p[k] is partial-sum slice k
//       and a[k], b[k] are the captured operand slices.
//     - The carry register takes c. Slice k covers bits [k*CHUNK_W +: CHUNK_W].
//     - After k = NCHUNK-1, go to DONE.
//   - DONE (1 cycle):
//     - sum <= partial sum; cout <= final carry; done=1 for exactly this cycle.
//     - Next state is LOAD.
//   - Timing:
//     - Period is NCHUNK+2 cycles (10 by default).
//     - The first done pulse comes 10 cycles after reset deassertion; later pulses every 10 cycles.
//   - Input changes outside the LOAD cycle are ignored until the next LOAD.
//     The result always corresponds to operands sampled at one LOAD edge.
//   - sum and cout change only in DONE (and at reset); they are stable between pulses.
//   - Arithmetic is modulo 2^DATA_W, with overflow reported only via cout.
//     The carry propagates across every slice boundary (full ripple through all chunks).
//   - done is low in LOAD and ADD and is never high for two consecutive cycles.
// TESTING
//   - Reset, then A=0, B=0, cin=1 -> first done 10 cycles after rst drops; sum=1, cout=0.
//   - A=B=256'hff, cin=1 held over a LOAD -> next done: sum=256'h1ff, cout=0.
//   - A=all-ones, B=0, cin=1 -> sum=0, cout=1.
//     Carry must cross all 8 slice boundaries.
//   - A=B=all-ones, cin=0 -> sum=all-ones minus 1 (LSB 0), cout=1.
//     Checks carry propagation within and across slices.
//   - Change A during ADD -> the current done reports the old operands; the next done reports the new ones.
//   - rst=1 for 1 cycle mid-ADD -> sum=0, cout=0, no done pulse.
//     Restart: done arrives 10 cycles after release.

Source files
------------

// File: rtl/adder_256bit.sv
// Multi-cycle wide adder: sum/cout = din_one + din_two + cin, one CHUNK_W
// slice per clock. Free-running LOAD -> ADD (NCHUNK cycles) -> DONE loop.
// The result registers and the done pulse update on the DONE edge, so done is
// high for the single cycle after that edge.
module adder_256bit #(
    parameter int DATA_W  = 256,
    parameter int CHUNK_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din_one,
    input  logic [DATA_W-1:0] din_two,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              done
);

    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  a_q, b_q;       // operands captured at LOAD
    logic [DATA_W-1:0]  psum_q;         // partial sum, filled slice by slice
    logic               carry_q;        // running carry between slices
    logic [IDX_W-1:0]   idx_q;          // current slice index
    logic [DATA_W-1:0]  sum_q;
    logic               cout_q;
    logic               done_q;

    logic [CHUNK_W-1:0] a_sl, b_sl;
    logic [CHUNK_W:0]   slice_d;        // {carry out, slice sum}

    // Slice adder for the current index; the carry-in is the running carry.
    always_comb begin
        a_sl    = a_q[int'(idx_q)*CHUNK_W +: CHUNK_W];
        b_sl    = b_q[int'(idx_q)*CHUNK_W +: CHUNK_W];
        slice_d = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK_W{1'b0}}, carry_q};
    end

    // Sequencer FSM with registered result and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    a_q     <= din_one;
                    b_q     <= din_two;
                    carry_q <= cin;
                    psum_q  <= '0;
                    idx_q   <= '0;
                    done_q  <= 1'b0;
                    state_q <= ADD;
                end
                ADD: begin
                    psum_q[int'(idx_q)*CHUNK_W +: CHUNK_W] <= slice_d[CHUNK_W-1:0];
                    carry_q <= slice_d[CHUNK_W];
                    done_q  <= 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    sum_q   <= psum_q;
                    cout_q  <= carry_q;
                    done_q  <= 1'b1;
                    state_q <= LOAD;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= LOAD;
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign done = done_q;

endmodule

// File: tb/tb_adder_256bit.sv
// Directed bench for adder_256bit: expected {cout,sum} pushed to a queue when
// operands are driven, popped and compared when done is observed.
module tb_adder_256bit;

    localparam int DATA_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] din_one, din_two;
    logic              cin;
    logic [DATA_W-1:0] sum;
    logic              cout, done;

    int checks = 0;
    int errors = 0;
    logic [DATA_W:0] sb_q[$];
    logic [DATA_W:0] last_exp;

    adder_256bit #(.DATA_W(DATA_W), .CHUNK_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .din_one (din_one),
        .din_two (din_two),
        .cin     (cin),
        .sum     (sum),
        .cout    (cout),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W:0] obs, input logic [DATA_W:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive operands and record the reference result.
    task automatic drive(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic c);
        din_one = a;
        din_two = b;
        cin     = c;
        sb_q.push_back({1'b0, a} + {1'b0, b} + (DATA_W+1)'(c));
    endtask

    // Count negedges until done is seen (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done !== 1'b1 && cyc < 40);
    endtask

    task automatic expect_result(input string tag, input int exp_cyc);
        int cyc;
        logic [DATA_W:0] e;
        wait_done(cyc);
        chk({tag, "_latency"}, (DATA_W+1)'(cyc), (DATA_W+1)'(exp_cyc));
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, (DATA_W+1)'(1), (DATA_W+1)'(0));
        end else begin
            e = sb_q.pop_front();
            last_exp = e;
            chk(tag, {cout, sum}, e);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] ones;
        logic [DATA_W-1:0] ra, rb;
        ones = '1;
        rst = 1'b1;
        din_one = '0;
        din_two = '0;
        cin = 1'b0;
        last_exp = '0;
        repeat (3) @(negedge clk);
        chk("reset_result", {cout, sum}, '0);
        chk("reset_done", (DATA_W+1)'(done), '0);

        // First result: 10 cycles after reset release.
        drive('0, '0, 1'b1);
        rst = 1'b0;
        expect_result("zero_cin", 10);

        drive(256'hff, 256'hff, 1'b1);
        expect_result("ff_ff_cin", 10);

        drive(ones, '0, 1'b1);
        expect_result("ones_cin_ripple", 10);

        drive(ones, ones, 1'b0);
        expect_result("ones_ones", 10);

        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < DATA_W/32; w++) begin
                ra[w*32 +: 32] = $urandom;
                rb[w*32 +: 32] = $urandom;
            end
            drive(ra, rb, 1'($urandom_range(0, 1)));
            expect_result("random", 10);
        end

        // Operand change mid-ADD: current result uses old operands.
        drive(256'h1234_5678, 256'h1, 1'b0);
        repeat (3) @(negedge clk);
        din_one = ones;
        expect_result("old_operands", 7);
        drive(din_one, din_two, cin);
        expect_result("new_operands", 10);

        // Reset mid-ADD abandons the computation.
        drive(256'hdead_beef, 256'h1111, 1'b1);
        repeat (4) @(negedge clk);
        chk("stable_between_pulses", {cout, sum}, last_exp);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_result", {cout, sum}, '0);
        chk("midrst_done", (DATA_W+1)'(done), '0);
        expect_result("after_midrst", 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
